// File: rtl/knn_pkg.sv
// knn_pkg: shared constants, class/count types and vote-state encoding for the kNN stages
package knn_pkg;
  localparam int CLASS_W     = 2;
  localparam int NUM_CLASSES = 2 ** CLASS_W;
  localparam int K_MAX       = 5;
  localparam int CNT_W       = 3;
  typedef logic [CLASS_W-1:0] class_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, COUNT, DECIDE, HOLD} vote_state_e;
  function automatic cnt_t clamp_k(input cnt_t k);
    return (k == '0) ? cnt_t'(1) : (k > cnt_t'(K_MAX)) ? cnt_t'(K_MAX) : k;
  endfunction
endpackage

// File: rtl/knn_argmax.sv
// knn_argmax: majority class over the vote counters, ties resolved toward the nearest rank
module knn_argmax
  import knn_pkg::*;
(
  input  cnt_t   cnt_i [NUM_CLASSES],
  input  class_t snap_i [K_MAX],
  input  cnt_t   k_eff_i,
  output class_t winner_o,
  output cnt_t   maxc_o
);
  always_comb begin
    maxc_o = '0;
    for (int c = 0; c < NUM_CLASSES; c++)
      maxc_o = (cnt_i[c] > maxc_o) ? cnt_i[c] : maxc_o;
    winner_o = snap_i[0];
    // Scanning farthest-first lets the nearest qualifying rank overwrite last.
    for (int r = K_MAX - 1; r >= 0; r--)
      winner_o = (CNT_W'(r) < k_eff_i && cnt_i[snap_i[r]] == maxc_o) ? snap_i[r] : winner_o;
  end
endmodule

// File: rtl/knn_vote.sv
// knn_vote: tallies the top-k neighbour classes one rank per cycle and
// hands the majority class downstream over valid/ready
module knn_vote
  import knn_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   k_use,
  input  logic [CLASS_W-1:0] class1,
  input  logic [CLASS_W-1:0] class2,
  input  logic [CLASS_W-1:0] class3,
  input  logic [CLASS_W-1:0] class4,
  input  logic [CLASS_W-1:0] class5,
  output logic               busy,
  output logic               pred_valid,
  output logic [CLASS_W-1:0] pred_class,
  output logic [CNT_W-1:0]   pred_count,
  input  logic               out_ready
);
  vote_state_e state_q;
  class_t      snap_q [K_MAX];
  cnt_t        cnt_q [NUM_CLASSES];
  cnt_t        idx_q, k_q, pred_count_q;
  class_t      pred_class_q;
  class_t      winner;
  cnt_t        maxc;

  knn_argmax u_argmax (
    .cnt_i    (cnt_q),
    .snap_i   (snap_q),
    .k_eff_i  (k_q),
    .winner_o (winner),
    .maxc_o   (maxc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      snap_q       <= '{default: '0};
      cnt_q        <= '{default: '0};
      idx_q        <= '0;
      k_q          <= '0;
      pred_class_q <= '0;
      pred_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          snap_q  <= '{class1, class2, class3, class4, class5};
          cnt_q   <= '{default: '0};
          idx_q   <= '0;
          k_q     <= clamp_k(k_use);
          state_q <= COUNT;
        end
        COUNT: begin
          cnt_q[snap_q[idx_q]] <= cnt_q[snap_q[idx_q]] + cnt_t'(1);
          idx_q                <= idx_q + cnt_t'(1);
          if (idx_q == k_q - cnt_t'(1)) state_q <= DECIDE;
        end
        DECIDE: begin
          pred_class_q <= winner;
          pred_count_q <= maxc;
          state_q      <= HOLD;
        end
        HOLD: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = state_q != IDLE;
  assign pred_valid = state_q == HOLD;
  assign pred_class = pred_class_q;
  assign pred_count = pred_count_q;
endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: directed vectors with hand-computed predictions for knn_vote
module tb_knn_vote;
  logic       clk = 0, reset = 1, start = 0, out_ready = 1;
  logic [2:0] k_use = 0;
  logic [1:0] class1 = 0, class2 = 0, class3 = 0, class4 = 0, class5 = 0;
  logic       busy, pred_valid;
  logic [1:0] pred_class;
  logic [2:0] pred_count;
  int passed = 0, total = 0;

  knn_vote dut (
    .clk(clk), .reset(reset), .start(start), .k_use(k_use),
    .class1(class1), .class2(class2), .class3(class3), .class4(class4), .class5(class5),
    .busy(busy), .pred_valid(pred_valid), .pred_class(pred_class), .pred_count(pred_count),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_classes(input logic [1:0] a, b, c, d, e);
    class1 = a; class2 = b; class3 = c; class4 = d; class5 = e;
  endtask

  // Start is raised just after a reference edge (edge 0); returns edges until pred_valid.
  task automatic launch_and_wait(output int n);
    start = 1;
    step();
    start = 0;
    n = 1;
    while (!pred_valid && n < 30) begin
      step();
      n++;
    end
  endtask

  task automatic vote(input string tag, input logic [1:0] a, b, c, d, e,
                      input logic [2:0] k, input int exp_cls, exp_cnt, exp_lat);
    int n;
    set_classes(a, b, c, d, e);
    k_use = k;
    out_ready = 1;
    launch_and_wait(n);
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_class"}, pred_class, exp_cls);
    check({tag, "_count"}, pred_count, exp_cnt);
    step();
    check({tag, "_done"}, {busy, pred_valid}, 0);
  endtask

  initial begin
    int n;
    step(); step();
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      check("idle", {busy, pred_valid, pred_class, pred_count}, 0);
      step();
    end
    vote("tiebreak", 2, 1, 2, 3, 1, 5, 2, 2, 7);
    vote("k3", 0, 3, 3, 1, 1, 3, 3, 2, 5);
    vote("k0", 0, 3, 3, 1, 1, 0, 0, 1, 3);
    vote("k7", 0, 3, 3, 1, 1, 7, 3, 2, 7);
    // Unanimous vote under backpressure, with a stray start during HOLD.
    set_classes(1, 1, 1, 1, 1);
    k_use = 5;
    out_ready = 0;
    launch_and_wait(n);
    check("unan_latency", n, 7);
    for (int i = 0; i < 4; i++) begin
      start = (i == 1);
      step();
      check("hold_stable", {busy, pred_valid, pred_class, pred_count}, {1'b1, 1'b1, 2'd1, 3'd5});
    end
    start = 0;
    out_ready = 1;
    step();
    check("hold_release", {busy, pred_valid}, 0);
    check("hold_keep", {pred_class, pred_count}, {2'd1, 3'd5});
    step();
    check("no_queued_start", busy, 0);
    // Inputs change right after the accepting edge.
    set_classes(0, 0, 1, 2, 0);
    k_use = 5;
    start = 1;
    step();
    start = 0;
    set_classes(3, 3, 3, 3, 3);
    k_use = 1;
    n = 1;
    while (!pred_valid && n < 30) begin
      step();
      n++;
    end
    check("snap_latency", n, 7);
    check("snap_result", {pred_class, pred_count}, {2'd0, 3'd3});
    step();
    // Reset while counting.
    set_classes(3, 3, 3, 3, 3);
    k_use = 5;
    start = 1;
    step();
    start = 0;
    step(); step();
    reset = 1;
    step();
    reset = 0;
    check("reset_abort", {busy, pred_valid}, 0);
    check("reset_pred", {pred_class, pred_count}, 0);
    vote("after_reset", 1, 2, 2, 3, 3, 5, 2, 2, 7);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
